mire_writer: RTL and testbench
==============================

MIRE_WRITER -- requirements
Module: mire_writer

Interface
REQ-001 SHALL have parameter HDISP, default 800: active pixels per line.
REQ-002 SHALL have parameter VDISP, default 480: active lines per frame.
REQ-003 SHALL have parameter BURST, default 64: writes per bus tenure before cyc is released.
REQ-004 SHALL have port wshb_ifm.clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port wshb_ifm.rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port wshb_ifm.ack, input, 1: slave acknowledge; a write completes on a cycle with cyc=stb=ack=1.
REQ-007 SHALL have port wshb_ifm.cyc, output, 1: bus cycle request.
REQ-008 SHALL have port wshb_ifm.stb, output, 1: strobe.
REQ-009 SHALL have port wshb_ifm.we, output, 1: write enable, constant 1.
REQ-010 SHALL have port wshb_ifm.sel, output, 4: byte select, constant 4'b1111.
REQ-011 SHALL have port wshb_ifm.cti, output, 3: constant 3'b000 (classic cycle).
REQ-012 SHALL have port wshb_ifm.bte, output, 2: constant 2'b00.
REQ-013 SHALL have port wshb_ifm.adr, output, 32: byte address of the current pixel.
REQ-014 SHALL have port wshb_ifm.dat_ms, output, 32: pixel data, {8'h00, RGB[23:0]}.
REQ-015 SHALL have port frame_done, output, 1: one-cycle pulse when the last pixel of a frame is acknowledged.

Function
REQ-016 SHALL fill the SDRAM framebuffer with a test pattern, pixel (x,y) at adr = 4*(y*HDISP + x), raster order, and repeat frames indefinitely.
REQ-017 SHALL drive dat_ms[23:0] = 24'hFFFFFF when x[3:0]==0 or y[3:0]==0, else 24'h000000; dat_ms[31:24] = 0.
REQ-018 SHALL implement an FSM with states WRITE and PAUSE.
REQ-019 In WRITE: cyc=stb=1; adr and dat_ms hold stable until ack.
REQ-020 On ack in WRITE: x increments; x==HDISP-1 wraps x to 0 and increments y; x==HDISP-1 and y==VDISP-1 wraps to (0,0) with adr=0.
REQ-021 adr SHALL be kept as a running counter incremented by 4 per ack, not recomputed by multiplication.
REQ-022 A burst counter SHALL count acks in WRITE; on the ack that makes BURST writes, the FSM enters PAUSE and the counter clears.
REQ-023 In PAUSE: cyc=stb=0 for exactly one cycle, then return to WRITE; adr/x/y unchanged.
REQ-024 frame_done SHALL pulse high in the cycle after the ack of pixel (HDISP-1,VDISP-1), for exactly one cycle.
REQ-025 Frame end and burst end coinciding SHALL both take effect: wrap to (0,0) and enter PAUSE.
REQ-026 ack while in PAUSE (cyc=0) SHALL be ignored.
REQ-027 Counter widths: x $clog2(HDISP), y $clog2(VDISP), burst $clog2(BURST+1); no overflow at parameter extremes.

Reset
REQ-028 On wshb_ifm.rst=1 at a clock edge: state=WRITE, x=y=0, adr=0, burst count=0, frame_done=0.
REQ-029 During reset cyc=stb=0; the first write is asserted on the cycle after reset deasserts.
REQ-030 Reset mid-burst SHALL abandon the pending write; the next frame restarts at adr 0.

Structure
REQ-031 The state enum typedef, the WHITE/BLACK colour constants, and the Wishbone cti/bte codes SHALL live in the shared video package.
REQ-032 SHALL be a single module with no sub-module.

Verification (bench parameters HDISP=32, VDISP=4, BURST=8; slave acks every cycle unless stated)
REQ-033 Release reset -> first cycle cyc=stb=we=1, adr=0, dat_ms=32'h00FFFFFF; second write has adr=4.
REQ-034 Continuous ack -> after 8 acks cyc=0 for exactly 1 cycle; the 9th write has adr=32.
REQ-035 Pixel (1,1) -> dat_ms=0; pixel (16,1) -> dat_ms=32'h00FFFFFF.
REQ-036 Complete 128 acks -> frame_done pulses once; the next adr is 0; the wrap coincides with PAUSE (128 mod 8 = 0).
REQ-037 Slave inserts 3 wait states -> adr/dat_ms stable across the wait; only one increment occurs.
REQ-038 Assert rst after 5 acks -> all outputs return to their reset values; after release, adr restarts at 0.

Source files
------------

// File: rtl/mire_writer_pkg.sv
// Shared video package for the test-pattern writer.
// Holds the writer FSM state type, the pattern colours, the Wishbone
// classic-cycle codes and the helper that maps pixel coordinates to bus data.
package mire_writer_pkg;

  typedef enum logic {
    ST_WRITE = 1'b0,
    ST_PAUSE = 1'b1
  } state_t;

  localparam logic [23:0] WHITE       = 24'hFFFFFF;
  localparam logic [23:0] BLACK       = 24'h000000;

  localparam logic [2:0]  CTI_CLASSIC = 3'b000;
  localparam logic [1:0]  BTE_LINEAR  = 2'b00;
  localparam logic [3:0]  SEL_ALL     = 4'b1111;

  // Grid pattern: a white line every 16 pixels horizontally and vertically.
  // Only the low four bits of each coordinate matter.
  function automatic logic [31:0] mire_pixel(input logic [3:0] x_lo,
                                             input logic [3:0] y_lo);
    logic [23:0] rgb;
    rgb = ((x_lo == 4'd0) || (y_lo == 4'd0)) ? WHITE : BLACK;
    return {8'h00, rgb};
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone bus bundle used between the pattern writer and the SDRAM
// controller. clk/rst travel with the bus so the master has a single
// clock/reset source.
//   master modport: inputs clk, rst, ack; outputs cyc, stb, we, sel, cti,
//   bte, adr (byte address), dat_ms (master-to-slave data).
interface wshb_if;
  logic        clk;
  logic        rst;
  logic        ack;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] adr;
  logic [31:0] dat_ms;

  modport master (
    input  clk, rst, ack,
    output cyc, stb, we, sel, cti, bte, adr, dat_ms
  );
endinterface

// File: rtl/mire_writer.sv
// Test-pattern ("mire") writer: fills an HDISP x VDISP framebuffer in SDRAM
// with a white 16-pixel grid on black, in raster order, forever.
// Writes are Wishbone classic single writes grouped in tenures of BURST
// acknowledged writes; after each tenure cyc/stb drop for one cycle so other
// masters can win arbitration.
// Ports:
//   wshb_ifm   : Wishbone master (clk, synchronous active-high rst, ack in;
//                cyc, stb, we, sel, cti, bte, adr, dat_ms out)
//   frame_done : one-cycle pulse the cycle after the last pixel is acked
module mire_writer
  import mire_writer_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int BURST = 64
) (
  wshb_if.master wshb_ifm,
  output logic   frame_done
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = $clog2(BURST + 1);
  // Number of coordinate bits that feed the 16-pixel grid test.
  localparam int XL = (XW < 4) ? XW : 4;
  localparam int YL = (YW < 4) ? YW : 4;

  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURST - 1);

  state_t        state_reg,      state_next;
  logic [XW-1:0] x_reg,          x_next;
  logic [YW-1:0] y_reg,          y_next;
  logic [31:0]   adr_reg,        adr_next;
  logic [BW-1:0] burst_reg,      burst_next;
  logic          frame_done_reg, frame_done_next;
  // Low for the whole reset and for the first edge after it, so the first
  // request appears on the cycle after reset is released and never while
  // reset is still asserted.
  logic          bus_en_reg;

  always_ff @(posedge wshb_ifm.clk) begin
    if (wshb_ifm.rst) begin
      state_reg      <= ST_WRITE;
      x_reg          <= '0;
      y_reg          <= '0;
      adr_reg        <= '0;
      burst_reg      <= '0;
      frame_done_reg <= 1'b0;
      bus_en_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      adr_reg        <= adr_next;
      burst_reg      <= burst_next;
      frame_done_reg <= frame_done_next;
      bus_en_reg     <= 1'b1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    x_next          = x_reg;
    y_next          = y_reg;
    adr_next        = adr_reg;
    burst_next      = burst_reg;
    frame_done_next = 1'b0;

    case (state_reg)
      ST_WRITE: begin
        // Only an ack seen while our request is visible completes a write.
        if (bus_en_reg && wshb_ifm.ack) begin
          // Address is a running byte counter; the frame wrap overrides it.
          adr_next = adr_reg + 32'd4;
          if (x_reg == X_LAST) begin
            x_next = '0;
            if (y_reg == Y_LAST) begin
              y_next          = '0;
              adr_next        = '0;
              frame_done_next = 1'b1;
            end else begin
              y_next = y_reg + YW'(1);
            end
          end else begin
            x_next = x_reg + XW'(1);
          end

          // Burst end is independent of frame end; both may apply at once.
          if (burst_reg == B_LAST) begin
            burst_next = '0;
            state_next = ST_PAUSE;
          end else begin
            burst_next = burst_reg + BW'(1);
          end
        end
      end
      ST_PAUSE: begin
        state_next = ST_WRITE;
      end
      default: begin
        state_next = ST_WRITE;
      end
    endcase
  end

  logic req;
  assign req = bus_en_reg && (state_reg == ST_WRITE);

  assign wshb_ifm.cyc    = req;
  assign wshb_ifm.stb    = req;
  assign wshb_ifm.we     = 1'b1;
  assign wshb_ifm.sel    = SEL_ALL;
  assign wshb_ifm.cti    = CTI_CLASSIC;
  assign wshb_ifm.bte    = BTE_LINEAR;
  assign wshb_ifm.adr    = adr_reg;
  assign wshb_ifm.dat_ms = mire_pixel(4'(x_reg[XL-1:0]), 4'(y_reg[YL-1:0]));
  assign frame_done      = frame_done_reg;

endmodule

// File: tb/tb_mire_writer.sv
// Self-checking bench for mire_writer (HDISP=32, VDISP=4, BURST=8).
// Each completed write pushes the next expected (adr, dat) onto a queue;
// each new write presented by the DUT pops and compares it.
module tb_mire_writer;

  localparam int H = 32;
  localparam int V = 4;
  localparam int B = 8;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  wshb_if wshb();
  logic   frame_done;

  mire_writer #(.HDISP(H), .VDISP(V), .BURST(B)) dut (
    .wshb_ifm   (wshb),
    .frame_done (frame_done)
  );

  initial wshb.clk = 1'b0;
  always #5 wshb.clk = ~wshb.clk;

  int   err_cnt = 0;
  int   chk_cnt = 0;

  exp_t exp_q[$];
  int   m_x, m_y, m_burst;
  bit   last_ack, last_cyc;
  bit   holding, expect_resume;
  logic [31:0] hold_adr, hold_dat;
  int   write_num, ack_count, fd_count;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_pixel(input int x, input int y);
    exp_t e;
    e.adr = 32'(4 * (y * H + x));
    e.dat = ((x % 16 == 0) || (y % 16 == 0)) ? 32'h00FFFFFF : 32'h0;
    return e;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_x = 0; m_y = 0; m_burst = 0;
    last_ack = 0; last_cyc = 0;
    holding = 0; expect_resume = 0;
    write_num = 0; ack_count = 0; fd_count = 0;
    exp_q.push_back(model_pixel(0, 0));
  endtask

  task automatic do_reset();
    wshb.rst = 1'b1;
    wshb.ack = 1'b0;
    repeat (3) @(negedge wshb.clk);
    check_eq("rst_cyc", 32'(wshb.cyc), 32'd0);
    check_eq("rst_stb", 32'(wshb.stb), 32'd0);
    check_eq("rst_adr", wshb.adr, 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    model_reset();
    wshb.rst = 1'b0;
    $display("reset released at %0t", $time);
  endtask

  // One clock: observe at the falling edge, then drive ack for the next
  // rising edge.
  task automatic tick(input bit ack_val);
    bit   completed, fd_exp, pause_now;
    exp_t e;
    @(negedge wshb.clk);
    completed = last_ack && last_cyc;
    fd_exp    = 0;
    pause_now = 0;
    if (completed) begin
      ack_count++;
      m_burst++;
      if (m_x == H - 1) begin
        m_x = 0;
        if (m_y == V - 1) begin
          m_y = 0;
          fd_exp = 1;
        end else begin
          m_y++;
        end
      end else begin
        m_x++;
      end
      if (m_burst == B) begin
        m_burst = 0;
        pause_now = 1;
      end
      exp_q.push_back(model_pixel(m_x, m_y));
      holding = 0;
      $display("ack #%0d adr=%h next=(%0d,%0d)", ack_count, hold_adr, m_x, m_y);
    end

    check_eq("frame_done", 32'(frame_done), 32'(fd_exp));
    if (frame_done) fd_count++;

    if (pause_now) begin
      check_eq("pause_cyc", 32'(wshb.cyc), 32'd0);
      expect_resume = 1;
    end else if (expect_resume) begin
      check_eq("resume_cyc", 32'(wshb.cyc), 32'd1);
      expect_resume = 0;
    end

    if (wshb.cyc) begin
      if (!holding) begin
        if (exp_q.size() == 0) begin
          check_eq("queue_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("adr", wshb.adr, e.adr);
          check_eq("dat", wshb.dat_ms, e.dat);
          check_eq("stb", 32'(wshb.stb), 32'd1);
          check_eq("we", 32'(wshb.we), 32'd1);
          check_eq("sel_cti_bte", {23'd0, wshb.sel, wshb.cti, wshb.bte},
                   {23'd0, 4'b1111, 3'b000, 2'b00});
          case (write_num)
            0:   begin
                   check_eq("first_adr", wshb.adr, 32'd0);
                   check_eq("first_dat", wshb.dat_ms, 32'h00FFFFFF);
                 end
            1:   check_eq("second_adr", wshb.adr, 32'd4);
            8:   check_eq("ninth_adr", wshb.adr, 32'd32);
            33:  check_eq("pix_1_1_dat", wshb.dat_ms, 32'h00000000);
            48:  check_eq("pix_16_1_dat", wshb.dat_ms, 32'h00FFFFFF);
            128: check_eq("wrap_adr", wshb.adr, 32'd0);
            default: ;
          endcase
          write_num++;
          hold_adr = wshb.adr;
          hold_dat = wshb.dat_ms;
          holding  = 1;
        end
      end else begin
        check_eq("hold_adr", wshb.adr, hold_adr);
        check_eq("hold_dat", wshb.dat_ms, hold_dat);
      end
    end

    last_ack = ack_val;
    last_cyc = wshb.cyc;
    wshb.ack = ack_val;
  endtask

  initial begin
    int budget;
    wshb.rst = 1'b1;
    wshb.ack = 1'b0;
    model_reset();

    // Reset, then continuous ack through a full frame and beyond.
    do_reset();
    repeat (150) tick(1'b1);
    check_eq("frame_done_count", 32'(fd_count), 32'd1);
    check_eq("acks_in_frame_run", 32'(ack_count >= 128), 32'd1);

    // Slave inserts three wait states before each ack.
    repeat (8) begin
      tick(1'b0);
      tick(1'b0);
      tick(1'b0);
      tick(1'b1);
    end

    // Reset mid-burst after five acks; the pending write is abandoned.
    do_reset();
    budget = 40;
    while (ack_count < 5 && budget > 0) begin
      tick(1'b1);
      budget--;
    end
    check_eq("five_acks_reached", 32'(ack_count), 32'd5);
    do_reset();
    repeat (20) tick(1'b1);
    check_eq("restart_writes", 32'(write_num > 8), 32'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
